// File: rtl/fabric_reset_seq.sv
// rtl/fabric_reset_seq.sv - fabric reset sequencer gated on synchronised PLL lock and device init
`timescale 1ns/1ps

module fabric_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 160
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       PLL_LOCK,
  input  logic       INIT_DONE,
  input  logic       SW_RST_REQ,
  input  logic       CLR_LOCK_LOST,
  output logic       FABRIC_RESET_N,
  output logic       LOCK_LOST,
  output logic [1:0] STATE
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] pll_sync_q;
  logic [SYNC_STAGES-1:0] init_sync_q;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic                   fab_rst_n_q;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lost_set;
  logic                   qual;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pll_sync_q  <= '0;
      init_sync_q <= '0;
    end else begin
      pll_sync_q  <= {pll_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
      init_sync_q <= {init_sync_q[SYNC_STAGES-2:0], INIT_DONE};
    end
  end

  assign qual = pll_sync_q[SYNC_STAGES-1] & init_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    hold_cnt_d = hold_cnt_q;
    lost_set   = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        state_d    = ST_WAIT;
        filt_cnt_d = '0;
        hold_cnt_d = '0;
      end
      ST_WAIT: begin
        if (!qual) begin
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FW'(LOCK_FILTER - 1)) begin
          state_d    = ST_HOLD;
          filt_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + FW'(1);
        end
      end
      ST_HOLD: begin
        if (!qual) begin
          state_d    = ST_WAIT;
          filt_cnt_d = '0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!qual) begin
          state_d  = ST_ASSERT;
          lost_set = 1'b1;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
    // Software request overrides the transition but a coincident lock loss is still recorded
    if (SW_RST_REQ) begin
      state_d    = ST_ASSERT;
      filt_cnt_d = '0;
      hold_cnt_d = '0;
    end
  end

  always_comb begin
    lock_lost_d = lock_lost_q;
    if (lost_set) begin
      lock_lost_d = 1'b1;
    end else if (CLR_LOCK_LOST) begin
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_ASSERT;
      filt_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      fab_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      fab_rst_n_q <= (state_d == ST_RUN);
      lock_lost_q <= lock_lost_d;
    end
  end

  assign FABRIC_RESET_N = fab_rst_n_q;
  assign LOCK_LOST      = lock_lost_q;
  assign STATE          = state_q;

endmodule
